dunc16_mem: RTL and testbench

- Word-addressed data/program memory directly downstream of the dunc16 CPU core.
- Consumes the core's ADDRESS, MD_OUT (write data) and DO_WRITE (write strobe), and serves read requests back on MMO.
- After reset, a sequencer fills the whole array with INIT_VAL before accepting traffic; BUSY tells the core to hold off.
- Out-of-range accesses are flagged on OOR and have no side effects.

---
 rtl/dunc16_mem.sv | 90 +++++++++
 tb/tb_dunc16_mem.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dunc16_mem.sv
// rtl/dunc16_mem.sv - dunc16 word-addressed memory with post-reset init sweep
// Registered reads with write-first bypass; out-of-range requests are flagged and have no side effects.
module dunc16_mem #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       ADDRESS,
  input  logic [DATA_W-1:0] MD_OUT,
  input  logic              DO_WRITE,
  input  logic              RD_REQ,
  output logic [DATA_W-1:0] MMO,
  output logic              RD_VALID,
  output logic              BUSY,
  output logic              OOR
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST    = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t              state, state_next;
  logic [ADDR_W:0]     cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   idx;
  logic                out_of_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign idx          = ADDRESS[ADDR_W-1:0];
  // Shifting out the implemented bits also covers ADDR_W=16, where nothing is left.
  assign out_of_range = (ADDRESS >> ADDR_W) != 16'd0;
  assign BUSY         = (state == S_INIT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = idx;
    mem_wdata  = MD_OUT;
    case (state)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt[ADDR_W-1:0];
        mem_wdata = INIT_VAL;
        if (cnt == LAST) state_next = S_IDLE;
      end
      S_IDLE:  mem_we = DO_WRITE && !out_of_range;
      default: state_next = S_INIT;
    endcase
  end

  // Array itself is not reset; the sweep defines its contents.
  always_ff @(posedge CLK) begin
    if (mem_we && RESET) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt      <= '0;
      MMO      <= '0;
      RD_VALID <= 1'b0;
      OOR      <= 1'b0;
    end else begin
      RD_VALID <= 1'b0;
      OOR      <= 1'b0;
      if (state == S_INIT) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        RD_VALID <= RD_REQ;
        OOR      <= (RD_REQ || DO_WRITE) && out_of_range;
        if (RD_REQ) begin
          if (out_of_range)  MMO <= '0;
          else if (DO_WRITE) MMO <= MD_OUT;
          else               MMO <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dunc16_mem.sv
// tb/tb_dunc16_mem.sv - directed self-checking bench for dunc16_mem
module tb_dunc16_mem;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] ADDRESS;
  logic [15:0] MD_OUT;
  logic        DO_WRITE;
  logic        RD_REQ;
  logic [15:0] MMO;
  logic        RD_VALID;
  logic        BUSY;
  logic        OOR;

  int checks   = 0;
  int failures = 0;
  int n;

  dunc16_mem dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .MD_OUT(MD_OUT),
    .DO_WRITE(DO_WRITE), .RD_REQ(RD_REQ), .MMO(MMO), .RD_VALID(RD_VALID),
    .BUSY(BUSY), .OOR(OOR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (BUSY && cycles < 1000);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic exp_oor);
    ADDRESS = a; MD_OUT = d; DO_WRITE = 1'b1;
    tick();
    DO_WRITE = 1'b0;
    check("wr_oor", OOR, exp_oor);
    check("wr_no_valid", RD_VALID, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input logic exp_oor);
    ADDRESS = a; RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0;
    check("rd_valid", RD_VALID, 1);
    check("rd_data", MMO, exp);
    check("rd_oor", OOR, exp_oor);
  endtask

  initial begin
    RESET = 1'b0; ADDRESS = '0; MD_OUT = '0; DO_WRITE = 1'b0; RD_REQ = 1'b0;
    repeat (3) tick();
    check("rst_busy", BUSY, 1);
    check("rst_mmo", MMO, 0);
    check("rst_valid", RD_VALID, 0);
    check("rst_oor", OOR, 0);

    // First sweep, with a write+read attempted at cycle 10 that must be ignored
    RESET = 1'b1;
    n = 0;
    do begin
      if (n == 9) begin
        ADDRESS = 16'h0003; MD_OUT = 16'h5555; DO_WRITE = 1'b1; RD_REQ = 1'b1;
      end
      tick();
      n++;
      if (n == 10) begin
        DO_WRITE = 1'b0; RD_REQ = 1'b0;
        check("busy_ignore_valid", RD_VALID, 0);
        check("busy_ignore_oor", OOR, 0);
        check("busy_mid", BUSY, 1);
      end
    end while (BUSY && n < 1000);
    check("init_cycles", n, 256);

    do_read(16'h0000, 16'h0000, 0);
    do_read(16'h007F, 16'h0000, 0);
    do_read(16'h00FF, 16'h0000, 0);
    do_read(16'h0003, 16'h0000, 0);

    do_write(16'h0012, 16'hBEEF, 0);
    do_read(16'h0012, 16'hBEEF, 0);
    tick();
    check("idle_valid_low", RD_VALID, 0);
    check("idle_mmo_hold", MMO, 16'hBEEF);
    do_read(16'h0013, 16'h0000, 0);

    // Simultaneous write and read: write-first bypass
    ADDRESS = 16'h0040; MD_OUT = 16'h1234; DO_WRITE = 1'b1; RD_REQ = 1'b1;
    tick();
    DO_WRITE = 1'b0; RD_REQ = 1'b0;
    check("bypass_data", MMO, 16'h1234);
    check("bypass_valid", RD_VALID, 1);
    do_read(16'h0040, 16'h1234, 0);

    // Back-to-back reads with RD_REQ held high
    RD_REQ = 1'b1;
    ADDRESS = 16'h0012; tick();
    check("b2b_0", MMO, 16'hBEEF); check("b2b_v0", RD_VALID, 1);
    ADDRESS = 16'h0013; tick();
    check("b2b_1", MMO, 16'h0000); check("b2b_v1", RD_VALID, 1);
    ADDRESS = 16'h0040; tick();
    check("b2b_2", MMO, 16'h1234); check("b2b_v2", RD_VALID, 1);
    RD_REQ = 1'b0;

    // Out of range
    do_write(16'h0105, 16'hAAAA, 1);
    do_read(16'h0005, 16'h0000, 0);
    do_read(16'h0012, 16'hBEEF, 0);
    do_read(16'h0105, 16'h0000, 1);
    do_read(16'hFFFF, 16'h0000, 1);
    tick();
    check("oor_pulse_end", OOR, 0);

    // Reset after traffic
    do_write(16'h0020, 16'h9999, 0);
    do_read(16'h0020, 16'h9999, 0);
    RESET = 1'b0;
    #1;
    check("async_rst_mmo", MMO, 0);
    check("async_rst_busy", BUSY, 1);
    check("async_rst_valid", RD_VALID, 0);
    repeat (2) tick();
    RESET = 1'b1;
    wait_init(n);
    check("reinit_cycles", n, 256);
    do_read(16'h0020, 16'h0000, 0);

    // Reset at cycle 100 of the sweep
    do_write(16'h0020, 16'h9999, 0);
    RESET = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    repeat (100) tick();
    check("mid_sweep_busy", BUSY, 1);
    RESET = 1'b0;
    #1;
    check("mid_sweep_rst_busy", BUSY, 1);
    repeat (2) tick();
    RESET = 1'b1;
    wait_init(n);
    check("restart_cycles", n, 256);
    do_read(16'h0020, 16'h0000, 0);
    do_read(16'h0012, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
